// File: rtl/av_upload_pkg.sv
// Shared types for the cart RAM upload responder.
// Holds the responder FSM state encoding and the default pad byte.
// No logic; imported by av_cart_upload.
package av_upload_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_DATA,
    PRESENT
  } upload_state_t;

  localparam logic [7:0] AV_PAD_BYTE_C = 8'hFF;

endpackage

// File: rtl/av_cart_upload.sv
// Purpose: serves HPS upload read strobes from cart RAM port A; returns PAD_BYTE past cart_size.
// Latency: in-range byte valid RAM_LATENCY+2 cycles after the strobe, pad byte after 2 cycles.
// Backpressure: ioctl_wait_o high while busy; strobes while busy are dropped and flagged in overrun_o.
// Optional: define AV_UPLOAD_CHECKSUM_EN for a 16-bit running byte sum on checksum_o.
module av_cart_upload
  import av_upload_pkg::*;
#(
  parameter int         ADDR_WIDTH  = 12,
  parameter int         RAM_LATENCY = 1,
  parameter logic [7:0] PAD_BYTE    = AV_PAD_BYTE_C
) (
  input  logic                  clk_11m_i,
  input  logic                  reset_n_i,
  input  logic                  ioctl_upload_i,
  input  logic                  ioctl_rd_i,
  input  logic [24:0]           ioctl_addr_i,
  output logic [7:0]            ioctl_din_o,
  output logic                  ioctl_wait_o,
  input  logic [12:0]           cart_size_i,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic                  ram_rd_o,
  input  logic [7:0]            ram_data_i,
  output logic                  upload_done_o,
  output logic                  overrun_o,
  output logic [15:0]           checksum_o
);

  upload_state_t         state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  pad_q;
  logic [1:0]            lat_cnt_q;
  logic [7:0]            din_q;
  logic                  wait_q;
  logic                  upload_q;
  logic                  done_q;
  logic                  overrun_q;
  logic                  present;
  logic                  accept;
  logic                  in_range;
  logic                  upload_rise;
  logic [7:0]            present_byte;

  // Address is servable only if no bit sits above the RAM window and it is below the image size.
  assign in_range     = ((ioctl_addr_i >> ADDR_WIDTH) == 25'd0) &&
                        (ioctl_addr_i < 25'(cart_size_i));
  assign accept       = ioctl_rd_i && ioctl_upload_i && (state_q == IDLE);
  assign upload_rise  = ioctl_upload_i && !upload_q;
  assign present_byte = pad_q ? PAD_BYTE : ram_data_i;

  // Next-state logic; a dropped upload session aborts any fetch without touching the data register.
  always_comb begin
    state_d  = state_q;
    ram_rd_o = 1'b0;
    present  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) state_d = in_range ? ISSUE : PRESENT;
      end
      ISSUE: begin
        ram_rd_o = 1'b1;
        state_d  = (RAM_LATENCY == 1) ? PRESENT : WAIT_DATA;
      end
      WAIT_DATA: begin
        if (lat_cnt_q == 2'd0) state_d = PRESENT;
      end
      PRESENT: begin
        present = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if ((state_q != IDLE) && !ioctl_upload_i) begin
      state_d = IDLE;
      present = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk_11m_i or negedge reset_n_i) begin
    if (!reset_n_i) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // Latch the request; RAM address only moves for in-range fetches.
  always_ff @(posedge clk_11m_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      addr_q <= '0;
      pad_q  <= 1'b0;
    end else if (accept) begin
      pad_q <= !in_range;
      if (in_range) addr_q <= ioctl_addr_i[ADDR_WIDTH-1:0];
    end
  end

  // Counts the extra RAM pipeline cycles spent in WAIT_DATA.
  always_ff @(posedge clk_11m_i or negedge reset_n_i) begin
    if (!reset_n_i)                                   lat_cnt_q <= 2'd0;
    else if (state_q == ISSUE)                        lat_cnt_q <= 2'(RAM_LATENCY - 2);
    else if (state_q == WAIT_DATA && lat_cnt_q != 0)  lat_cnt_q <= lat_cnt_q - 2'd1;
  end

  // Returned byte, wait flag and session edge tracking.
  always_ff @(posedge clk_11m_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      din_q    <= 8'h00;
      wait_q   <= 1'b0;
      upload_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      if (present) din_q <= present_byte;
      wait_q   <= (state_d != IDLE);
      upload_q <= ioctl_upload_i;
      done_q   <= upload_q && !ioctl_upload_i;
    end
  end

  // Sticky overrun: a live-session strobe landing while busy; cleared when a new session starts.
  always_ff @(posedge clk_11m_i or negedge reset_n_i) begin
    if (!reset_n_i)                                               overrun_q <= 1'b0;
    else if (ioctl_rd_i && ioctl_upload_i && (state_q != IDLE))   overrun_q <= 1'b1;
    else if (upload_rise)                                         overrun_q <= 1'b0;
  end

`ifdef AV_UPLOAD_CHECKSUM_EN
  logic [15:0] checksum_q;

  // Wrapping sum of every presented byte, restarted at each session start.
  always_ff @(posedge clk_11m_i or negedge reset_n_i) begin
    if (!reset_n_i)       checksum_q <= 16'h0000;
    else if (upload_rise) checksum_q <= 16'h0000;
    else if (present)     checksum_q <= checksum_q + {8'h00, present_byte};
  end

  assign checksum_o = checksum_q;
`else
  assign checksum_o = 16'h0000;
`endif

  assign ioctl_din_o   = din_q;
  assign ioctl_wait_o  = wait_q;
  assign ram_addr_o    = addr_q;
  assign upload_done_o = done_q;
  assign overrun_o     = overrun_q;

endmodule

// File: tb/tb_av_cart_upload.sv
// Bench for av_cart_upload: two instances (RAM latency 1 and 2) driven by the same directed stimulus.
// A cycle-counting model predicts every output each cycle; literal checks pin the headline cases.
// Outputs are compared on the falling clock edge.
module tb_av_cart_upload;

  localparam int LAT [2] = '{1, 2};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        upload;
  logic        rd;
  logic [24:0] addr;
  logic [12:0] size;

  logic [7:0]  din1, din2, rdat1, rdat2;
  logic        wait1, wait2, rd1, rd2, done1, done2, ov1, ov2;
  logic [11:0] ra1, ra2;
  logic [15:0] cs1, cs2;

  logic [7:0]  mem [0:4095];
  logic [7:0]  p1, q2a, q2b;

  int errors = 0;
  int checks = 0;

  // model state
  int          cyc;
  logic        up_prev;
  logic        done_e;
  int          bu    [2];
  logic [7:0]  pv    [2];
  logic [7:0]  din_e [2];
  logic        ov_e  [2];
  logic        wait_e[2];
  logic        rd_e  [2];
  logic [11:0] ra_e  [2];
  logic [15:0] cs_e  [2];

  // watch results
  int          w1, w2, r1, r2;
  logic [11:0] a1;

  always #5 clk = ~clk;

  // RAM port A models: 1-cycle and 2-cycle read pipelines
  always @(posedge clk) begin
    if (rd1) p1 <= mem[ra1];
    if (rd2) q2a <= mem[ra2];
    q2b <= q2a;
  end
  assign rdat1 = p1;
  assign rdat2 = q2b;

  av_cart_upload #(.ADDR_WIDTH(12), .RAM_LATENCY(1), .PAD_BYTE(8'hFF)) u1 (
    .clk_11m_i(clk), .reset_n_i(rst_n), .ioctl_upload_i(upload), .ioctl_rd_i(rd),
    .ioctl_addr_i(addr), .ioctl_din_o(din1), .ioctl_wait_o(wait1), .cart_size_i(size),
    .ram_addr_o(ra1), .ram_rd_o(rd1), .ram_data_i(rdat1), .upload_done_o(done1),
    .overrun_o(ov1), .checksum_o(cs1));

  av_cart_upload #(.ADDR_WIDTH(12), .RAM_LATENCY(2), .PAD_BYTE(8'hFF)) u2 (
    .clk_11m_i(clk), .reset_n_i(rst_n), .ioctl_upload_i(upload), .ioctl_rd_i(rd),
    .ioctl_addr_i(addr), .ioctl_din_o(din2), .ioctl_wait_o(wait2), .cart_size_i(size),
    .ram_addr_o(ra2), .ram_rd_o(rd2), .ram_data_i(rdat2), .upload_done_o(done2),
    .overrun_o(ov2), .checksum_o(cs2));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an accepted read occupies the block until cycle bu (exclusive); the byte lands at bu.
  task automatic model_step();
    logic inr;
    if (!rst_n) begin
      cyc = 0; up_prev = 1'b0; done_e = 1'b0;
      for (int k = 0; k < 2; k++) begin
        bu[k] = 0; pv[k] = 8'h00; din_e[k] = 8'h00; ov_e[k] = 1'b0;
        wait_e[k] = 1'b0; rd_e[k] = 1'b0; ra_e[k] = 12'h000; cs_e[k] = 16'h0000;
      end
      return;
    end
    done_e = up_prev && !upload;
    for (int k = 0; k < 2; k++) begin
      rd_e[k] = 1'b0;
      if (upload && !up_prev) begin
        ov_e[k] = 1'b0;
        cs_e[k] = 16'h0000;
      end
      if (cyc < bu[k]) begin
        if (!upload) bu[k] = cyc + 1;
        else begin
          if (rd) ov_e[k] = 1'b1;
          if (cyc == bu[k] - 1) begin
            din_e[k] = pv[k];
`ifdef AV_UPLOAD_CHECKSUM_EN
            cs_e[k] = cs_e[k] + {8'h00, pv[k]};
`endif
          end
        end
      end else if (rd && upload) begin
        inr   = (addr < 25'(size)) && (addr < 25'd4096);
        bu[k] = cyc + (inr ? 2 + LAT[k] : 2);
        pv[k] = inr ? mem[addr[11:0]] : 8'hFF;
        if (inr) begin
          rd_e[k] = 1'b1;
          ra_e[k] = addr[11:0];
        end
      end
      wait_e[k] = (cyc + 1 < bu[k]);
    end
    up_prev = upload;
    cyc++;
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      chk("din_l1",  32'(din1),  32'(din_e[0]));
      chk("din_l2",  32'(din2),  32'(din_e[1]));
      chk("wait_l1", 32'(wait1), 32'(wait_e[0]));
      chk("wait_l2", 32'(wait2), 32'(wait_e[1]));
      chk("rd_l1",   32'(rd1),   32'(rd_e[0]));
      chk("rd_l2",   32'(rd2),   32'(rd_e[1]));
      chk("done_l1", 32'(done1), 32'(done_e));
      chk("done_l2", 32'(done2), 32'(done_e));
      chk("ovr_l1",  32'(ov1),   32'(ov_e[0]));
      chk("ovr_l2",  32'(ov2),   32'(ov_e[1]));
      chk("csum_l1", 32'(cs1),   32'(cs_e[0]));
      chk("csum_l2", 32'(cs2),   32'(cs_e[1]));
      if (rd_e[0]) chk("raddr_l1", 32'(ra1), 32'(ra_e[0]));
      if (rd_e[1]) chk("raddr_l2", 32'(ra2), 32'(ra_e[1]));
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic strobe(input logic [24:0] a);
    rd = 1'b1; addr = a;
    @(posedge clk); #1;
    rd = 1'b0;
  endtask

  // Count wait-high cycles and RAM reads over n cycles starting with the current one.
  task automatic watch(input int n);
    w1 = 0; w2 = 0; r1 = 0; r2 = 0; a1 = 12'h000;
    repeat (n) begin
      @(negedge clk);
      if (wait1) w1++;
      if (wait2) w2++;
      if (rd1) begin r1++; a1 = ra1; end
      if (rd2) r2++;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    for (int i = 0; i < 4096; i++) mem[i] = (i < 16) ? 8'(8'hA0 + i) : 8'h00;
    rst_n = 1'b0; upload = 1'b0; rd = 1'b0; addr = '0; size = 13'd16;
    fork
      compare_loop();
      forever begin
        @(posedge clk or negedge rst_n);
        model_step();
      end
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_din",   32'(din1),  32'h00);
    chk("reset_wait",  32'(wait2), 32'h0);
    chk("reset_raddr", 32'(ra1),   32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    upload = 1'b1;
    tick(); tick();

    // in-range read, latency 1 and 2
    strobe(25'd5);
    watch(6);
    chk("rd5_wait_cycles_l1", 32'(w1), 32'd2);
    chk("rd5_wait_cycles_l2", 32'(w2), 32'd3);
    chk("rd5_din_l1", 32'(din1), 32'hA5);
    chk("rd5_din_l2", 32'(din2), 32'hA5);
    chk("rd5_ram_reads", 32'(r1), 32'd1);
    chk("rd5_ram_addr", 32'(a1), 32'd5);

    // out-of-range reads
    strobe(25'd16);
    watch(4);
    chk("pad16_wait_cycles", 32'(w1), 32'd1);
    chk("pad16_din", 32'(din1), 32'hFF);
    chk("pad16_ram_reads", 32'(r1 + r2), 32'd0);
    strobe(25'h1000);
    watch(4);
    chk("pad1000_wait_cycles", 32'(w2), 32'd1);
    chk("pad1000_din", 32'(din2), 32'hFF);
    chk("pad1000_ram_reads", 32'(r1 + r2), 32'd0);

    // new session, sequential dump back-to-back
    upload = 1'b0; tick(); tick();
    upload = 1'b1; tick();
    for (int i = 0; i < 16; i++) begin
      strobe(25'(i));
      n = 0;
      while (wait2 && n < 20) begin tick(); n++; end
      if (n >= 20) chk("seq_timeout", 32'(wait2), 32'h0);
      chk("seq_din_l2", 32'(din2), 32'(8'hA0 + i));
    end
`ifdef AV_UPLOAD_CHECKSUM_EN
    chk("seq_checksum_l2", 32'(cs2), 32'h0A78);
    chk("seq_checksum_l1", 32'(cs1), 32'h0A78);
`else
    chk("seq_checksum_l2", 32'(cs2), 32'h0000);
`endif
    chk("pre_overrun", 32'(ov1), 32'h0);

    // overrun: second strobe one cycle after the first
    rd = 1'b1; addr = 25'd7;
    tick();
    addr = 25'd9;
    tick();
    rd = 1'b0;
    watch(6);
    chk("ovr_flag_l1", 32'(ov1), 32'h1);
    chk("ovr_flag_l2", 32'(ov2), 32'h1);
    chk("ovr_din_l1", 32'(din1), 32'hA7);
    chk("ovr_din_l2", 32'(din2), 32'hA7);
    tick(); tick(); tick();
    chk("ovr_sticky", 32'(ov1), 32'h1);

    // abort: upload drops in the cycle after a strobe
    rd = 1'b1; addr = 25'd2;
    tick();
    rd = 1'b0; upload = 1'b0;
    @(negedge clk);
    chk("abort_wait_t1", 32'(wait1), 32'h1);
    @(negedge clk);
    chk("abort_wait_l1", 32'(wait1), 32'h0);
    chk("abort_wait_l2", 32'(wait2), 32'h0);
    chk("abort_din_l1", 32'(din1), 32'hA7);
    chk("abort_din_l2", 32'(din2), 32'hA7);
    chk("abort_done", 32'(done1), 32'h1);
    @(negedge clk);
    chk("abort_done_off", 32'(done1), 32'h0);
    @(posedge clk); #1;
    upload = 1'b1;
    tick(); tick();
    chk("ovr_cleared", 32'(ov1), 32'h0);

    // asynchronous reset while latency-2 instance waits on RAM
    strobe(25'd9);
    @(posedge clk); #2;
    chk("rst_pre_wait_l2", 32'(wait2), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_wait_l2", 32'(wait2), 32'h0);
    chk("rst_async_wait_l1", 32'(wait1), 32'h0);
    chk("rst_async_din",     32'(din2),  32'h00);
    chk("rst_async_raddr",   32'(ra2),   32'h000);
    chk("rst_async_rd",      32'(rd2),   32'h0);
    chk("rst_async_ovr",     32'(ov1),   32'h0);
    chk("rst_async_csum",    32'(cs2),   32'h0000);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    strobe(25'd3);
    watch(6);
    chk("post_rst_din_l1", 32'(din1), 32'hA3);
    chk("post_rst_din_l2", 32'(din2), 32'hA3);

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
